// File: rtl/mux_8a1_pkg.sv
// Shared types and the 8:1 select function for the ALU result selector.
// Latency: none; pure types and a combinational helper.
// Backpressure: not applicable.
package mux_8a1_pkg;

    localparam int N_INPUTS = 8;
    localparam int SEL_W    = 3;
    // Widest data word the shared select function can carry; instances
    // narrower than this are zero-extended in and truncated back out.
    localparam int MAX_W    = 64;

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [MAX_W-1:0] word_t;

    // Fully decoded 8:1 select; every code maps to one input, so no X path.
    function automatic word_t mux_select(
        input sel_t  sel,
        input word_t d0,
        input word_t d1,
        input word_t d2,
        input word_t d3,
        input word_t d4,
        input word_t d5,
        input word_t d6,
        input word_t d7
    );
        word_t res;
        res = d0;
        case (sel)
            3'd0: res = d0;
            3'd1: res = d1;
            3'd2: res = d2;
            3'd3: res = d3;
            3'd4: res = d4;
            3'd5: res = d5;
            3'd6: res = d6;
            3'd7: res = d7;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mux_8a1_reg.sv
// Enabled capture register for the selected word, its select code and a valid flag.
// Latency: one core clock edge from d/sel/en to q/sel_q/valid_q.
// Backpressure: none; en=0 holds data and drops valid for that cycle.
// Optional: MUX_8A1_PARITY_EN adds par_q, the XOR parity of the captured word.
module mux_8a1_reg
    import mux_8a1_pkg::*;
#(
    parameter int               WIDTH   = 6,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    input  sel_t             sel,
`ifdef MUX_8A1_PARITY_EN
    output logic             par_q,
`endif
    output logic [WIDTH-1:0] q,
    output sel_t             sel_q,
    output logic             valid_q
);

    // Capture word and select on enable; valid marks exactly the cycle after a capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q       <= RST_VAL;
            sel_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= en;
            if (en) begin
                q     <= d;
                sel_q <= sel;
            end
        end
    end

`ifdef MUX_8A1_PARITY_EN
    // Parity is computed from the same word being captured so it always matches q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else if (en) begin
            par_q <= ^d;
        end
    end
`endif

endmodule

// File: rtl/mux_8a1.sv
// 8:1 ALU result selector: combinational out plus a registered copy for downstream stages.
// Latency: out is zero-cycle; out_q/sel_q/valid_q are one cycle after an en=1 edge.
// Backpressure: none; en gates capture, reset only touches the registered path.
// Optional: MUX_8A1_PARITY_EN adds the par_q output.
module mux_8a1
    import mux_8a1_pkg::*;
#(
    parameter int               WIDTH   = 6,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [WIDTH-1:0] d4,
    input  logic [WIDTH-1:0] d5,
    input  logic [WIDTH-1:0] d6,
    input  logic [WIDTH-1:0] d7,
    input  logic             en,
`ifdef MUX_8A1_PARITY_EN
    output logic             par_q,
`endif
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic [2:0]       sel_q
    ,
    output logic             valid_q
);

    logic [WIDTH-1:0] sel_word;

    // One select feeds both the live output and the register input, so the
    // registered copy is always exactly what out showed at the capture edge.
    assign sel_word = WIDTH'(mux_select(sel,
                                        word_t'(d0), word_t'(d1), word_t'(d2), word_t'(d3),
                                        word_t'(d4), word_t'(d5), word_t'(d6), word_t'(d7)));

    assign out = sel_word;

    mux_8a1_reg #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
    ) u_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .d       (sel_word),
        .sel     (sel),
`ifdef MUX_8A1_PARITY_EN
        .par_q   (par_q),
`endif
        .q       (out_q),
        .sel_q   (sel_q),
        .valid_q (valid_q)
    );

endmodule

// File: tb/tb_mux_8a1.sv
// Directed self-checking bench for mux_8a1 (WIDTH=6, RST_VAL=0).
// Inputs are driven at the falling edge, outputs sampled 1 ns later or 1 ns after a rising edge.
// Build with MUX_8A1_PARITY_EN to exercise par_q.
module tb_mux_8a1;

    logic       clk;
    logic       rst_n;
    logic [2:0] sel;
    logic [5:0] dv [8];
    logic       en;
    logic [5:0] out;
    logic [5:0] out_q;
    logic [2:0] sel_q;
    logic       valid_q;
`ifdef MUX_8A1_PARITY_EN
    logic       par_q;
`endif

    int checks = 0;
    int errors = 0;

    mux_8a1 #(.WIDTH(6), .RST_VAL(6'h00)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sel     (sel),
        .d0      (dv[0]),
        .d1      (dv[1]),
        .d2      (dv[2]),
        .d3      (dv[3]),
        .d4      (dv[4]),
        .d5      (dv[5]),
        .d6      (dv[6]),
        .d7      (dv[7]),
        .en      (en),
`ifdef MUX_8A1_PARITY_EN
        .par_q   (par_q),
`endif
        .out     (out),
        .out_q   (out_q),
        .sel_q   (sel_q),
        .valid_q (valid_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        sel   = 3'd4;
        for (int i = 0; i < 8; i++) dv[i] = 6'(8'h20 + i);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_q !== 6'h00) begin errors++; $display("FAIL reset_out_q got %h want %h", out_q, 6'h00); end
        checks++;
        if (sel_q !== 3'd0) begin errors++; $display("FAIL reset_sel_q got %0d want 0", sel_q); end
        checks++;
        if (valid_q !== 1'b0) begin errors++; $display("FAIL reset_valid_q got %b want 0", valid_q); end
        checks++;
        if (out !== 6'h24) begin errors++; $display("FAIL reset_out got %h want %h", out, 6'h24); end
`ifdef MUX_8A1_PARITY_EN
        checks++;
        if (par_q !== 1'b0) begin errors++; $display("FAIL reset_par_q got %b want 0", par_q); end
`endif
        // Release and check the very first edge captures.
        @(negedge clk);
        rst_n = 1'b1;
        sel   = 3'd6;
        @(posedge clk);
        #1;
        checks++;
        if (out_q !== 6'h26) begin errors++; $display("FAIL first_capture_out_q got %h want %h", out_q, 6'h26); end
        checks++;
        if (sel_q !== 3'd6 || valid_q !== 1'b1) begin
            errors++; $display("FAIL first_capture_flags got sel_q=%0d valid_q=%b want 6 1", sel_q, valid_q);
        end
    endtask

    task automatic test_static_select();
        @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 8; i++) dv[i] = 6'(i);
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            #1;
            checks++;
            if (out !== 6'(s)) begin errors++; $display("FAIL static_sel%0d_early got %h want %h", s, out, 6'(s)); end
            #8;
            checks++;
            if (out !== 6'(s)) begin errors++; $display("FAIL static_sel%0d_late got %h want %h", s, out, 6'(s)); end
            #1;
        end
    endtask

    task automatic test_data_inversion();
        sel   = 3'd0;
        dv[0] = 6'h3F;
        #1;
        checks++;
        if (out !== 6'h3F) begin errors++; $display("FAIL inv_d0 got %h want 3f", out); end
        dv[1] = 6'h3E;
        #1;
        checks++;
        if (out !== 6'h3F) begin errors++; $display("FAIL inv_unselected got %h want 3f", out); end
        sel = 3'd1;
        #1;
        checks++;
        if (out !== 6'h3E) begin errors++; $display("FAIL inv_d1 got %h want 3e", out); end
    endtask

    task automatic test_registered();
        @(negedge clk);
        for (int i = 0; i < 8; i++) dv[i] = 6'(i);
        en    = 1'b1;
        sel   = 3'd5;
        dv[5] = 6'h05;
        @(posedge clk);
        #1;
        checks++;
        if (out_q !== 6'h05 || sel_q !== 3'd5 || valid_q !== 1'b1) begin
            errors++;
            $display("FAIL reg_capture got out_q=%h sel_q=%0d valid_q=%b want 05 5 1", out_q, sel_q, valid_q);
        end
        @(negedge clk);
        en  = 1'b0;
        sel = 3'd2;
        @(posedge clk);
        #1;
        checks++;
        if (out_q !== 6'h05 || sel_q !== 3'd5) begin
            errors++; $display("FAIL reg_hold got out_q=%h sel_q=%0d want 05 5", out_q, sel_q);
        end
        checks++;
        if (valid_q !== 1'b0) begin errors++; $display("FAIL reg_hold_valid got %b want 0", valid_q); end
        checks++;
        if (out !== 6'h02) begin errors++; $display("FAIL reg_hold_out got %h want 02", out); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        en    = 1'b1;
        sel   = 3'd7;
        dv[7] = 6'h07;
        @(posedge clk);
        #1;
        checks++;
        if (out_q !== 6'h07) begin errors++; $display("FAIL arst_pre got %h want 07", out_q); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_q !== 6'h00 || sel_q !== 3'd0 || valid_q !== 1'b0) begin
            errors++;
            $display("FAIL arst_clear got out_q=%h sel_q=%0d valid_q=%b want 00 0 0", out_q, sel_q, valid_q);
        end
        checks++;
        if (out !== 6'h07) begin errors++; $display("FAIL arst_out got %h want 07", out); end
        @(posedge clk);
        #1;
        checks++;
        if (out_q !== 6'h00 || valid_q !== 1'b0) begin
            errors++; $display("FAIL arst_hold got out_q=%h valid_q=%b want 00 0", out_q, valid_q);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sel   = 3'd3;
        @(posedge clk);
        #1;
        checks++;
        if (out_q !== 6'h03 || sel_q !== 3'd3 || valid_q !== 1'b1) begin
            errors++;
            $display("FAIL arst_release got out_q=%h sel_q=%0d valid_q=%b want 03 3 1", out_q, sel_q, valid_q);
        end
    endtask

    // Reference select written as an explicit table, independent of sel arithmetic.
    function automatic logic [5:0] ref_mux(input logic [2:0] s);
        logic [5:0] r;
        r = 6'h00;
        case (s)
            3'd0: r = dv[0];
            3'd1: r = dv[1];
            3'd2: r = dv[2];
            3'd3: r = dv[3];
            3'd4: r = dv[4];
            3'd5: r = dv[5];
            3'd6: r = dv[6];
            3'd7: r = dv[7];
        endcase
        return r;
    endfunction

    task automatic test_sweep();
        logic [5:0] exp_w;
        int         errs_before;
        errs_before = errors;
        en = 1'b1;
        for (int step = 0; step < 2000; step++) begin
            @(negedge clk);
            sel = 3'(step);
            for (int n = 0; n < 8; n++) begin
                int inv;
                inv   = ((step * 10) / (80 << n)) % 2;
                dv[n] = 6'(n * 7 + 3) ^ (inv != 0 ? 6'h3F : 6'h00);
            end
            exp_w = ref_mux(sel);
            #1;
            checks++;
            if (out !== exp_w && errors - errs_before < 10) begin
                errors++; $display("FAIL sweep_out step %0d got %h want %h", step, out, exp_w);
            end else if (out !== exp_w) errors++;
            @(posedge clk);
            #1;
            checks++;
            if ((out_q !== exp_w || sel_q !== 3'(step)) && errors - errs_before < 10) begin
                errors++; $display("FAIL sweep_out_q step %0d got %h want %h", step, out_q, exp_w);
            end else if (out_q !== exp_w || sel_q !== 3'(step)) errors++;
        end
    endtask

`ifdef MUX_8A1_PARITY_EN
    task automatic test_parity();
        @(negedge clk);
        en    = 1'b1;
        sel   = 3'd0;
        dv[0] = 6'h07;
        @(posedge clk);
        #1;
        checks++;
        if (par_q !== 1'b1) begin errors++; $display("FAIL parity_07 got %b want 1", par_q); end
        @(negedge clk);
        dv[0] = 6'h03;
        @(posedge clk);
        #1;
        checks++;
        if (par_q !== 1'b0) begin errors++; $display("FAIL parity_03 got %b want 0", par_q); end
        @(negedge clk);
        en    = 1'b0;
        dv[0] = 6'h01;
        @(posedge clk);
        #1;
        checks++;
        if (par_q !== 1'b0) begin errors++; $display("FAIL parity_hold got %b want 0", par_q); end
    endtask
`endif

    initial begin
        test_reset();
        test_static_select();
        test_data_inversion();
        test_registered();
        test_async_reset();
        test_sweep();
`ifdef MUX_8A1_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_8a1.md
Name: mux_8a1

Overview:
- 8-to-1 multiplexer of WIDTH-bit data words, selected by a 3-bit code.
- Combinational output `out` follows the selected input with zero latency.
- Registered copy `out_q` (plus `sel_q`, `valid_q`) gives downstream ALU stages a timing-clean, one-cycle-delayed version.
- Used as the ALU result selector: each Dn is one operation's result.

Parameters:
- WIDTH, 6, bit width of every data input and of out/out_q.
- RST_VAL, 0, value loaded into out_q on reset (WIDTH bits, zero-extended).

Ports:
- clk  input  1  system clock; all registers update on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sel  input  3  select code; 0 picks d0 … 7 picks d7.
- d0..d7  input  WIDTH each  data inputs (eight separate ports, order d0..d7).
- en  input  1  capture enable for the registered path.
- out  output  WIDTH  combinational selected word.
- out_q  output  WIDTH  registered selected word.
- sel_q  output  3  sel value captured alongside out_q.
- valid_q  output  1  high for the cycle after any capture with en=1.

Behaviour:
- Combinational path:
  - out = d[sel] at all times, including during reset.
  - No latches; every sel code 0..7 is decoded, so no default/X case exists.
  - A change on sel or on the selected dn propagates to out in the same delta; changes on unselected inputs have no effect on out.
- Registered path:
  - rst_n low (asynchronous, immediate) forces out_q=RST_VAL, sel_q=0, valid_q=0. These hold while rst_n is low.
  - First capture happens on the first rising clk edge with rst_n high.
  - On a rising edge with en=1: out_q <= d[sel], sel_q <= sel, valid_q <= 1. Latency is one cycle.
  - On a rising edge with en=0: out_q and sel_q hold; valid_q <= 0.
  - Reset asserted mid-stream clears the registers instantly; out is unaffected.
  - sel and data changing in the same cycle: out_q captures the d[sel] pair present at the edge.
- Width rule: no arithmetic is performed; bits pass through unmodified, MSB to MSB.

Optional Feature:
- Macro: MUX_8A1_PARITY_EN.
- When defined:
  - Extra output port par_q (1 bit) = even parity (XOR reduction) of the word captured into out_q, registered with it.
  - par_q resets to 0 and holds when en=0.
- When undefined: the par_q port and its logic do not exist; all other behaviour is identical.

Decomposition:
- Package mux_8a1_pkg holds:
  - localparam N_INPUTS=8 and SEL_W=3;
  - typedef sel_t (logic [SEL_W-1:0]);
  - function mux_select(sel, d0..d7), shared by the combinational path and the register input.
- One sub-module, mux_8a1_reg: the WIDTH+3+1 bit enabled register with async active-low reset and the optional parity bit. The top-level instantiates it once.

Test Plan:
1. Static select: d0..d7 = 0..7, sweep sel 0→7 every 10 ns → out equals sel (0,1,…,7) each step, with no glitch to another value.
2. Data inversion: d0 = ~0 = 6'h3F, sel=0 → out=6'h3F. Then d1 = 6'h3E with sel=0 → out stays 6'h3F (unselected input ignored).
3. Registered latency, with en=1:
   - sel=5, d5=6'h05 → after one clk edge out_q=6'h05, sel_q=5, valid_q=1.
   - Then en=0, sel=2 → out_q stays 6'h05 and valid_q=0, while out=6'h02.
4. Async reset mid-operation: out_q=6'h07; drop rst_n between clock edges → out_q=0, sel_q=0, valid_q=0 immediately, while out still tracks d[sel]. Release rst_n → next edge with en=1 captures normally.
5. Counter-driven sweep: sel[0], sel[1], sel[2] toggle every 10/20/40 ns; dn inverted every 80·2^n ns → out always matches a reference model of d[sel] over 20 µs.
6. With MUX_8A1_PARITY_EN: capture 6'h07 → par_q=1; capture 6'h03 → par_q=0.
